// File: rtl/port_io_pkg.sv
// Shared definitions for the port I/O expander: bus slot states, CMD byte layout
// and the command validity check used by the slave FSM.
package port_io_pkg;
  localparam int NPORTS_MAX  = 16;
  localparam int GW          = $clog2(NPORTS_MAX);
  localparam int CMD_IDX_LSB = 0;
  localparam int CMD_IDX_MSB = 3;
  localparam int CMD_RSV_LSB = 4;
  localparam int CMD_RSV_MSB = 7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_RD, ST_WR, ST_DIR, ST_HUNT
  } state_e;

  // A CMD byte is valid only when it names the expected group and the reserved nibble is clear.
  function automatic logic cmd_ok(input logic [7:0] b, input logic [GW-1:0] g);
    return (b[CMD_RSV_MSB:CMD_RSV_LSB] == '0) && (b[CMD_IDX_MSB:CMD_IDX_LSB] == g);
  endfunction
endpackage

// File: rtl/port_io_if.sv
// Control/status side of the port I/O bus; the byte lane and pins stay plain inout nets.
interface port_io_if;
  logic port_rst;
  logic err_clr;
  logic frame_ok;
  logic sync_err;
  modport master (output port_rst, err_clr, input frame_ok, sync_err);
  modport slave  (input port_rst, err_clr, output frame_ok, sync_err);
endinterface

// File: rtl/port_io_pin_bank.sv
// One 8-bit pin port: output and direction registers plus the input synchroniser.
// The top turns pin_out/pin_oe into the actual tristate drive.
module port_io_pin_bank #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_out,
  input  logic       wr_dir,
  input  logic [7:0] wdata,
  input  logic [7:0] pin_in,
  output logic [7:0] pin_out,
  output logic [7:0] pin_oe,
  output logic [7:0] pin_sync
);
  logic [7:0] out_q, out_d, dir_q, dir_d;
  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;

  always_comb begin
    out_d  = wr_out ? wdata : out_q;
    dir_d  = wr_dir ? wdata : dir_q;
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      dir_q  <= '0;
      sync_q <= '0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      sync_q <= sync_d;
    end
  end

  assign pin_out  = out_q;
  assign pin_oe   = dir_q;
  assign pin_sync = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/port_io_expander.sv
// Slave end of the port I/O serial bus: per-group CMD/RD/WR/DIR slot FSM, data-lane
// tristate and NPORTS pin banks.
module port_io_expander
  import port_io_pkg::*;
#(
  parameter int NPORTS      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  port_io_if.slave            bus,
  inout  wire  [7:0]          data,
  inout  wire  [8*NPORTS-1:0] pin
);
  state_e state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [7:0] rd_q, rd_d, rd_sel;
  logic err_q, err_d, fok_q, fok_d;
  logic data_oe;
  logic [NPORTS-1:0] wr_out, wr_dir;
  logic [NPORTS-1:0][7:0] pin_out, pin_oe, pin_sync;

  always_comb begin
    rd_sel = '0;
    wr_out = '0;
    wr_dir = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (g_q == k[GW-1:0]) begin
        rd_sel    = pin_sync[k];
        wr_out[k] = (state_q == ST_WR)  && !bus.port_rst;
        wr_dir[k] = (state_q == ST_DIR) && !bus.port_rst;
      end
    end
  end

  // port_rst wins over every slot; a new error beats err_clr in the same cycle.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rd_d    = rd_q;
    err_d   = err_q & ~bus.err_clr;
    fok_d   = 1'b0;
    if (bus.port_rst) begin
      state_d = ST_CMD;
      g_d     = '0;
    end else begin
      case (state_q)
        ST_CMD: begin
          if (cmd_ok(data, g_q)) begin
            state_d = ST_RD;
            rd_d    = rd_sel;
          end else begin
            state_d = ST_HUNT;
            err_d   = 1'b1;
          end
        end
        ST_RD:  state_d = ST_WR;
        ST_WR:  state_d = ST_DIR;
        ST_DIR: begin
          if (g_q == GW'(NPORTS-1)) begin
            state_d = ST_IDLE;
            fok_d   = 1'b1;
          end else begin
            state_d = ST_CMD;
            g_d     = g_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      fok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      fok_q   <= fok_d;
    end
  end

  assign bus.frame_ok = fok_q;
  assign bus.sync_err = err_q;

  // Releasing on port_rst keeps the lane free for the host's restarted frame.
  assign data_oe = (state_q == ST_RD) && !bus.port_rst;
  assign data    = data_oe ? rd_q : 8'hzz;

  for (genvar k = 0; k < NPORTS; k++) begin : g_bank
    port_io_pin_bank #(.SYNC_STAGES(SYNC_STAGES)) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_out   (wr_out[k]),
      .wr_dir   (wr_dir[k]),
      .wdata    (data),
      .pin_in   (pin[8*k +: 8]),
      .pin_out  (pin_out[k]),
      .pin_oe   (pin_oe[k]),
      .pin_sync (pin_sync[k])
    );
  end

  for (genvar b = 0; b < 8*NPORTS; b++) begin : g_pin
    assign pin[b] = pin_oe[b/8][b%8] ? pin_out[b/8][b%8] : 1'bz;
  end
endmodule

// File: tb/tb_port_io_expander.sv
// Directed bench for port_io_expander acting as the bus host, with an external
// driver on port 1 pins.
module tb_port_io_expander;
  import port_io_pkg::*;
  localparam int NP = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic host_oe;
  logic [7:0] host_byte;
  logic ext_en;
  logic [7:0] ext_val;
  wire  [7:0] data;
  wire  [8*NP-1:0] pin;
  int n_vec = 0;
  int n_err = 0;

  port_io_if bus_if ();

  port_io_expander #(.NPORTS(NP), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if),
    .data  (data),
    .pin   (pin)
  );

  assign data       = host_oe ? host_byte : 8'hzz;
  assign pin[15:8]  = ext_en ? ext_val : 8'hzz;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_rst();
    bus_if.port_rst = 1'b1;
    host_oe = 1'b0;
    tick();
    bus_if.port_rst = 1'b0;
  endtask

  task automatic slot_host(input string tag, input logic [7:0] b);
    host_oe   = 1'b1;
    host_byte = b;
    #1;
    chk({tag, "_data_oe"}, 32'(dut.data_oe), 32'd0);
    tick();
  endtask

  task automatic slot_rd(input logic [7:0] exp, input logic [7:0] mask);
    host_oe = 1'b0;
    #1;
    chk("rd_data_oe", 32'(dut.data_oe), 32'd1);
    if (mask != 8'h00) chk("rd_data", 32'(data & mask), 32'(exp & mask));
    tick();
  endtask

  task automatic group(input logic [3:0] g, input logic [7:0] wr, input logic [7:0] dir,
                       input logic [7:0] exp, input logic [7:0] mask);
    slot_host("cmd", {4'h0, g});
    slot_rd(exp, mask);
    slot_host("wr", wr);
    slot_host("dir", dir);
  endtask

  task automatic frame_end();
    chk("frame_ok_pulse", 32'(bus_if.frame_ok), 32'd1);
    host_oe = 1'b0;
    tick();
    chk("frame_ok_clear", 32'(bus_if.frame_ok), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.port_rst = 1'b0;
    bus_if.err_clr  = 1'b0;
    host_oe = 1'b0; host_byte = 8'h00;
    ext_en = 1'b0; ext_val = 8'h00;
    #12;
    chk("rst_sync_err", 32'(bus_if.sync_err), 32'd0);
    chk("rst_frame_ok", 32'(bus_if.frame_ok), 32'd0);
    chk("rst_data_oe", 32'(dut.data_oe), 32'd0);
    chk("rst_pin_oe", 32'(dut.pin_oe), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full frame writing A5/A6/A7 with all bits as outputs
    frame_rst();
    group(4'd0, 8'hA5, 8'hFF, 8'h00, 8'h00);
    group(4'd1, 8'hA6, 8'hFF, 8'h00, 8'h00);
    group(4'd2, 8'hA7, 8'hFF, 8'h00, 8'h00);
    chk("pin0_a5", 32'(pin[7:0]), 32'hA5);
    chk("pin1_a6", 32'(pin[15:8]), 32'hA6);
    chk("pin2_a7", 32'(pin[23:16]), 32'hA7);
    frame_end();

    // Readback of driven outputs, then turn port 1 into an input
    frame_rst();
    group(4'd0, 8'hA5, 8'hFF, 8'hA5, 8'hFF);
    group(4'd1, 8'h00, 8'h00, 8'hA6, 8'hFF);
    group(4'd2, 8'hA7, 8'hFF, 8'hA7, 8'hFF);
    chk("pin1_oe_off", 32'(dut.pin_oe[1]), 32'h00);
    frame_end();
    ext_en = 1'b1; ext_val = 8'h3C;
    tick(); tick(); tick();
    frame_rst();
    group(4'd0, 8'hA5, 8'hFF, 8'hA5, 8'hFF);
    group(4'd1, 8'h00, 8'h00, 8'h3C, 8'hFF);
    group(4'd2, 8'hA7, 8'hFF, 8'hA7, 8'hFF);
    frame_end();

    // Wrong group index in CMD -> HUNT, nothing applied
    frame_rst();
    group(4'd0, 8'hA5, 8'hFF, 8'hA5, 8'hFF);
    slot_host("bad_cmd", 8'h02);
    chk("hunt_sync_err", 32'(bus_if.sync_err), 32'd1);
    chk("hunt_state", 32'(dut.state_q), 32'(ST_HUNT));
    slot_host("hunt_wr", 8'h55);
    slot_host("hunt_dir", 8'h55);
    chk("hunt_pin1_oe", 32'(dut.pin_oe[1]), 32'h00);
    chk("hunt_pin1_ext", 32'(pin[15:8]), 32'h3C);
    chk("hunt_no_frame_ok", 32'(bus_if.frame_ok), 32'd0);
    frame_rst();
    group(4'd0, 8'hA5, 8'hFF, 8'hA5, 8'hFF);
    group(4'd1, 8'h00, 8'h00, 8'h3C, 8'hFF);
    group(4'd2, 8'hA7, 8'hFF, 8'hA7, 8'hFF);
    chk("err_sticky", 32'(bus_if.sync_err), 32'd1);
    frame_end();
    bus_if.err_clr = 1'b1; tick(); bus_if.err_clr = 1'b0;
    chk("err_clr", 32'(bus_if.sync_err), 32'd0);

    // Reserved nibble set while err_clr is pulsed: the error wins
    frame_rst();
    bus_if.err_clr = 1'b1;
    slot_host("rsv_cmd", 8'h10);
    bus_if.err_clr = 1'b0;
    chk("err_clr_vs_set", 32'(bus_if.sync_err), 32'd1);
    bus_if.err_clr = 1'b1; tick(); bus_if.err_clr = 1'b0;
    chk("err_clr2", 32'(bus_if.sync_err), 32'd0);

    // port_rst during RD of group 2
    frame_rst();
    group(4'd0, 8'hA5, 8'hFF, 8'hA5, 8'hFF);
    group(4'd1, 8'h00, 8'h00, 8'h3C, 8'hFF);
    slot_host("cmd", 8'h02);
    host_oe = 1'b0;
    #1;
    chk("rd2_oe_before", 32'(dut.data_oe), 32'd1);
    chk("rd2_data", 32'(data), 32'hA7);
    bus_if.port_rst = 1'b1;
    #1;
    chk("rd2_released", 32'(dut.data_oe), 32'd0);
    tick();
    bus_if.port_rst = 1'b0;
    chk("restart_state", 32'(dut.state_q), 32'(ST_CMD));
    chk("restart_pin0", 32'(pin[7:0]), 32'hA5);
    chk("restart_pin2", 32'(pin[23:16]), 32'hA7);
    group(4'd0, 8'hA5, 8'hFF, 8'hA5, 8'hFF);
    group(4'd1, 8'h00, 8'h00, 8'h3C, 8'hFF);
    group(4'd2, 8'hA7, 8'hFF, 8'hA7, 8'hFF);
    frame_end();

    // Port 0 low nibble output only
    frame_rst();
    group(4'd0, 8'hFF, 8'h0F, 8'hA5, 8'hFF);
    group(4'd1, 8'h00, 8'h00, 8'h3C, 8'hFF);
    group(4'd2, 8'hA7, 8'hFF, 8'hA7, 8'hFF);
    chk("nib_pin_lo", 32'(pin[3:0]), 32'hF);
    chk("nib_pin_oe", 32'(dut.pin_oe[0]), 32'h0F);
    frame_end();
    tick(); tick();
    frame_rst();
    group(4'd0, 8'hFF, 8'h0F, 8'h0F, 8'h0F);
    group(4'd1, 8'h00, 8'h00, 8'h3C, 8'hFF);
    group(4'd2, 8'hA7, 8'hFF, 8'hA7, 8'hFF);
    frame_end();

    // Async reset in the WR slot with a pending error
    frame_rst();
    slot_host("bad_cmd2", 8'h20);
    chk("pre_rst_err", 32'(bus_if.sync_err), 32'd1);
    frame_rst();
    slot_host("cmd", 8'h00);
    slot_rd(8'h0F, 8'h0F);
    host_oe = 1'b1; host_byte = 8'h12;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pin_oe", 32'(dut.pin_oe), 32'd0);
    chk("arst_data_oe", 32'(dut.data_oe), 32'd0);
    chk("arst_sync_err", 32'(bus_if.sync_err), 32'd0);
    chk("arst_state", 32'(dut.state_q), 32'(ST_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
